// File: rtl/sink_enable_sequencer_pkg.sv
// Shared types and sizing for the sink enable sequencer.
// Optional feature macro used by the top and interface: SINK_SEQ_PERF_CNT_EN.
package sink_seq_pkg;

   localparam int NUM_STREAMS     = 4;
   localparam int CNT_W           = 16;
   localparam int MAX_OUTSTANDING = 2;
   localparam int CREDIT_W        = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   typedef struct packed {
      logic [NUM_STREAMS-1:0] mask;
      logic [CNT_W-1:0]       count;
   } cmd_t;

endpackage

// File: rtl/sink_enable_sequencer_if.sv
// Command, enable-fork and status signals of the sink enable sequencer.
// stall_cycles exists only when SINK_SEQ_PERF_CNT_EN is defined.
interface sink_enable_sequencer_if;
   import sink_seq_pkg::*;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // a raised valid holds, with stable data, until its transfer.
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [NUM_STREAMS-1:0] cmd_mask;
   logic [CNT_W-1:0]       cmd_count;
   logic                   flush;
   logic [NUM_STREAMS-1:0] en_valid;
   logic [NUM_STREAMS-1:0] en_ready;
   logic [NUM_STREAMS-1:0] en_data;
   logic [NUM_STREAMS-1:0] done;
   logic                   busy;
   logic                   err_underflow;
   logic [31:0]            epochs_issued;
`ifdef SINK_SEQ_PERF_CNT_EN
   logic [31:0]            stall_cycles;
`endif

   modport master (
      output cmd_valid, cmd_mask, cmd_count, flush, en_ready, done,
`ifdef SINK_SEQ_PERF_CNT_EN
      input  stall_cycles,
`endif
      input  cmd_ready, en_valid, en_data, busy, err_underflow, epochs_issued
   );

   modport slave (
      input  cmd_valid, cmd_mask, cmd_count, flush, en_ready, done,
`ifdef SINK_SEQ_PERF_CNT_EN
      output stall_cycles,
`endif
      output cmd_ready, en_valid, en_data, busy, err_underflow, epochs_issued
   );

endinterface

// File: rtl/sink_enable_sequencer_credit_counter.sv
// Per-sink count of issued-but-unfinished epochs; saturates at zero and flags underflow.
module sink_credit_counter
   import sink_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty,
   output logic underflow
);

   logic [CREDIT_W-1:0] cnt_q, cnt_d;

   // inc is only ever raised while not full, so the count cannot overflow.
   always_comb begin
      cnt_d     = cnt_q;
      underflow = 1'b0;
      if (inc && !dec) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
         if (cnt_q == '0) begin
            underflow = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign full  = (cnt_q == CREDIT_W'(MAX_OUTSTANDING));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/sink_enable_sequencer.sv
// Broadcasts a latched enable mask to every sink, count times, with forked handshakes
// and per-sink credits. SINK_SEQ_PERF_CNT_EN adds the stall_cycles counter.
module sink_enable_sequencer
   import sink_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   sink_enable_sequencer_if.slave  bus
);

   state_t                 state_q, state_d;
   logic [NUM_STREAMS-1:0] acked_q, acked_d;
   logic [NUM_STREAMS-1:0] en_data_q, en_data_d;
   logic [CNT_W-1:0]       remaining_q, remaining_d;
   logic [31:0]            epochs_q, epochs_d;
   logic                   err_q, err_d;

   logic [NUM_STREAMS-1:0] full, empty, underflow;
   logic [NUM_STREAMS-1:0] en_valid, hs, acked_all;
   logic                   cmd_acc, retire;
   logic [CNT_W-1:0]       rem_eff;
   cmd_t                   cmd;

   assign cmd       = '{mask: bus.cmd_mask, count: bus.cmd_count};
   assign en_valid  = (state_q == ISSUE) ? (~acked_q & ~full) : '0;
   assign hs        = en_valid & bus.en_ready;
   assign acked_all = acked_q | hs;
   assign cmd_acc   = (state_q == IDLE) && bus.cmd_valid;
   assign retire    = (state_q == ISSUE) && (&acked_all);
   // flush shrinks the job to the word already in flight.
   assign rem_eff   = bus.flush ? CNT_W'(1) : remaining_q;

   for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_credit
      sink_credit_counter u_credit (
         .clk       (clk),
         .rst       (rst),
         .inc       (hs[i]),
         .dec       (bus.done[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .underflow (underflow[i])
      );
   end

   always_comb begin
      state_d     = state_q;
      acked_d     = acked_q;
      en_data_d   = en_data_q;
      remaining_d = remaining_q;
      epochs_d    = epochs_q;
      err_d       = err_q | (|underflow);
      case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               en_data_d   = cmd.mask;
               remaining_d = cmd.count;
               acked_d     = '0;
               if (cmd.count != '0) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (retire) begin
               acked_d     = '0;
               epochs_d    = epochs_q + 32'd1;
               remaining_d = rem_eff - 1'b1;
               if (rem_eff == CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end else begin
               acked_d     = acked_all;
               remaining_d = rem_eff;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acked_q     <= '0;
         en_data_q   <= '0;
         remaining_q <= '0;
         epochs_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acked_q     <= acked_d;
         en_data_q   <= en_data_d;
         remaining_q <= remaining_d;
         epochs_q    <= epochs_d;
         err_q       <= err_d;
      end
   end

   assign bus.cmd_ready     = (state_q == IDLE);
   assign bus.en_valid      = en_valid;
   assign bus.en_data       = en_data_q;
   assign bus.busy          = (state_q != IDLE) || !(&empty);
   assign bus.err_underflow = err_q;
   assign bus.epochs_issued = epochs_q;

`ifdef SINK_SEQ_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;

   // A stall is any pending sink that is either out of credit or not ready.
   always_comb begin
      stall_d = stall_q;
      if (cmd_acc) begin
         stall_d = '0;
      end else if ((state_q == ISSUE) &&
                   ((|(~acked_q & ~en_valid)) || (|(en_valid & ~bus.en_ready)))) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sink_enable_sequencer.sv
// Bench for sink_enable_sequencer: command table plus hand-written fork, credit,
// flush, zero-count/underflow and mid-operation reset sequences.
module tb_sink_enable_sequencer;
   import sink_seq_pkg::*;

   typedef struct {
      logic [3:0]  mask;
      logic [15:0] count;
      logic [31:0] exp_epochs;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sink_enable_sequencer_if bus ();

   sink_enable_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [3:0]  exp_q[$];
   logic [31:0] exp_epochs;
   logic        auto_done;
   logic [3:0]  tb_acked, prev_v, prev_hs, hs_last, m_hs;
   logic [3:0]  popped;
   vec_t        vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: advance past the edge, then drive done from last cycle's handshakes.
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.done = auto_done ? hs_last : 4'b0000;
   endtask

   task automatic send_cmd(input logic [3:0] m, input logic [15:0] c);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_mask  = m;
      bus.cmd_count = c;
      @(negedge clk);
      while (!bus.cmd_ready && n < 100) begin
         cyc();
         @(negedge clk);
         n++;
      end
      chk("cmd_accept_wait", {31'd0, bus.cmd_ready}, 32'd1);
      for (int k = 0; k < int'(c); k++) exp_q.push_back(m);
      cyc();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_epochs(input logic [31:0] target);
      int n = 0;
      while (bus.epochs_issued != target && n < 300) begin
         cyc();
         n++;
      end
   endtask

   // Scoreboard/monitor: pops one expected word each time all sinks have accepted it.
   always @(negedge clk) begin
      if (rst) begin
         tb_acked = '0;
         prev_v   = '0;
         prev_hs  = '0;
         hs_last  = '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (prev_v[i] && !prev_hs[i]) chk("valid_hold", {31'd0, bus.en_valid[i]}, 32'd1);
         end
         m_hs = bus.en_valid & bus.en_ready;
         if (m_hs != 4'b0000 && (&(tb_acked | m_hs))) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: word %0h retired with nothing expected", bus.en_data);
            end else begin
               popped = exp_q.pop_front();
               chk("sb_en_data", {28'd0, bus.en_data}, {28'd0, popped});
            end
            tb_acked = '0;
         end else begin
            tb_acked = tb_acked | m_hs;
         end
         prev_v  = bus.en_valid;
         prev_hs = m_hs;
         hs_last = m_hs;
      end
   end

   initial begin
      vecs[0] = '{4'b0101, 16'd3, 32'd3};
      vecs[1] = '{4'b1111, 16'd1, 32'd4};
      vecs[2] = '{4'b0000, 16'd2, 32'd6};
      vecs[3] = '{4'b1010, 16'd4, 32'd10};
      vecs[4] = '{4'b0011, 16'd0, 32'd10};
      vecs[5] = '{4'b1100, 16'd7, 32'd17};

      rst           = 1'b1;
      auto_done     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_mask  = '0;
      bus.cmd_count = '0;
      bus.flush     = 1'b0;
      bus.en_ready  = 4'b1111;
      bus.done      = '0;
      exp_epochs    = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_en_valid", {28'd0, bus.en_valid}, 32'd0);
      chk("rst_en_data", {28'd0, bus.en_data}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_err", {31'd0, bus.err_underflow}, 32'd0);
      chk("rst_epochs", bus.epochs_issued, 32'd0);
      cyc();

      // Table: all sinks ready, done follows every accept.
      auto_done = 1'b1;
      for (int v = 0; v < 6; v++) begin
         send_cmd(vecs[v].mask, vecs[v].count);
         wait_epochs(vecs[v].exp_epochs);
         repeat (3) cyc();
         @(negedge clk);
         chk("tbl_epochs", bus.epochs_issued, vecs[v].exp_epochs);
         chk("tbl_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
         chk("tbl_busy", {31'd0, bus.busy}, 32'd0);
         chk("tbl_sb_drained", exp_q.size(), 32'd0);
         cyc();
      end
      exp_epochs = 17;

      // Fork: sink 2 not ready for 5 cycles.
      bus.en_ready = 4'b1011;
      send_cmd(4'b1100, 16'd1);
      cyc();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fork_en_valid", {28'd0, bus.en_valid}, 32'h4);
         chk("fork_no_retire", bus.epochs_issued, exp_epochs);
         cyc();
      end
      bus.en_ready = 4'b1111;
      @(negedge clk);
      chk("fork_last_valid", {28'd0, bus.en_valid}, 32'h4);
      cyc();
      exp_epochs = exp_epochs + 1;
      @(negedge clk);
      chk("fork_retired", bus.epochs_issued, exp_epochs);
      chk("fork_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      repeat (3) cyc();

      // Credit limit: no done, two words then stall.
      auto_done = 1'b0;
      send_cmd(4'b0110, 16'd4);
      repeat (6) cyc();
      @(negedge clk);
      chk("credit_two_words", bus.epochs_issued, exp_epochs + 2);
      chk("credit_stall_valid", {28'd0, bus.en_valid}, 32'd0);
      chk("credit_busy", {31'd0, bus.busy}, 32'd1);
      chk("credit_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      bus.done = 4'b1111;
      cyc();
      @(negedge clk);
      chk("credit_freed_valid", {28'd0, bus.en_valid}, 32'hf);
      repeat (4) cyc();
      @(negedge clk);
      chk("credit_third_word", bus.epochs_issued, exp_epochs + 3);
      chk("credit_stall_again", {28'd0, bus.en_valid}, 32'd0);
      bus.done = 4'b1111;
      cyc();
      cyc();
      @(negedge clk);
      exp_epochs = exp_epochs + 4;
      chk("credit_fourth_word", bus.epochs_issued, exp_epochs);
      chk("credit_idle", {31'd0, bus.cmd_ready}, 32'd1);
      chk("credit_busy_outstanding", {31'd0, bus.busy}, 32'd1);
      bus.done = 4'b1111;
      cyc();
      bus.done = 4'b1111;
      cyc();
      @(negedge clk);
      chk("credit_drained_busy", {31'd0, bus.busy}, 32'd0);
      cyc();

      // Flush with the second word half accepted.
      auto_done = 1'b1;
      send_cmd(4'b1001, 16'd5);
      cyc();
      bus.en_ready = 4'b0011;
      cyc();
      bus.flush = 1'b1;
      cyc();
      bus.flush    = 1'b0;
      bus.en_ready = 4'b1111;
      cyc();
      exp_epochs = exp_epochs + 2;
      @(negedge clk);
      chk("flush_epochs", bus.epochs_issued, exp_epochs);
      chk("flush_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("flush_en_valid", {28'd0, bus.en_valid}, 32'd0);
      chk("flush_dropped_words", exp_q.size(), 32'd3);
      exp_q.delete();
      cyc();
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      chk("flush_idle_ignored", {31'd0, bus.cmd_ready}, 32'd1);
      chk("flush_idle_epochs", bus.epochs_issued, exp_epochs);
      chk("flush_busy", {31'd0, bus.busy}, 32'd0);
      cyc();

      // Zero count, then underflow on sink 1.
      auto_done = 1'b0;
      send_cmd(4'b1111, 16'd0);
      @(negedge clk);
      chk("zero_en_valid", {28'd0, bus.en_valid}, 32'd0);
      chk("zero_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("zero_epochs", bus.epochs_issued, exp_epochs);
      chk("zero_err_clear", {31'd0, bus.err_underflow}, 32'd0);
      cyc();
      bus.done = 4'b0010;
      cyc();
      @(negedge clk);
      chk("underflow_set", {31'd0, bus.err_underflow}, 32'd1);
      repeat (4) cyc();
      @(negedge clk);
      chk("underflow_sticky", {31'd0, bus.err_underflow}, 32'd1);
      chk("underflow_busy", {31'd0, bus.busy}, 32'd0);
      cyc();

      // Reset while half of a word is accepted.
      bus.en_ready = 4'b0011;
      send_cmd(4'b0110, 16'd3);
      cyc();
      @(negedge clk);
      chk("prereset_valid", {28'd0, bus.en_valid}, 32'hc);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("midrst_en_valid", {28'd0, bus.en_valid}, 32'd0);
      chk("midrst_en_data", {28'd0, bus.en_data}, 32'd0);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_err", {31'd0, bus.err_underflow}, 32'd0);
      chk("midrst_epochs", bus.epochs_issued, 32'd0);
      exp_q.delete();
      exp_epochs = 0;
      cyc();
      rst = 1'b0;
      bus.en_ready = 4'b1111;
      auto_done = 1'b1;
      cyc();
      send_cmd(4'b1110, 16'd2);
      wait_epochs(32'd2);
      repeat (3) cyc();
      @(negedge clk);
      chk("postrst_epochs", bus.epochs_issued, 32'd2);
      chk("postrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("postrst_sb_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
